ps2_host_tx: RTL and testbench

// Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse.

---
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift a
// command byte on the device clock, then check the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    output logic       CLK_MOUSE_OUT_EN,
    output logic       DATA_MOUSE_OUT_EN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       ACK_ERR
);

    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t        state_q;
    logic [1:0]    clk_s_q;
    logic [1:0]    data_s_q;
    logic          clk_prev_q;
    logic [9:0]    frame_q;
    logic [3:0]    bits_q;
    logic [CW-1:0] cnt_q;
    logic          fall;
    logic          tmo;

    // Synchronisers idle high so reset release never looks like a fall.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_s_q    <= 2'b11;
            data_s_q   <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_s_q    <= {clk_s_q[0], CLK_MOUSE_IN};
            data_s_q   <= {data_s_q[0], DATA_MOUSE_IN};
            clk_prev_q <= clk_s_q[1];
        end
    end

    assign fall = clk_prev_q & ~clk_s_q[1];
    assign tmo  = (cnt_q == TMO_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q           <= S_IDLE;
            frame_q           <= '0;
            bits_q            <= '0;
            cnt_q             <= '0;
            CLK_MOUSE_OUT_EN  <= 1'b0;
            DATA_MOUSE_OUT_EN <= 1'b0;
            BUSY              <= 1'b0;
            BYTE_SENT         <= 1'b0;
            ACK_ERR           <= 1'b0;
        end else begin
            BYTE_SENT <= 1'b0;
            ACK_ERR   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (SEND_BYTE) begin
                        frame_q          <= {1'b1, ~^BYTE_TO_SEND,
                                             BYTE_TO_SEND};
                        bits_q           <= '0;
                        cnt_q            <= '0;
                        BUSY             <= 1'b1;
                        CLK_MOUSE_OUT_EN <= 1'b1;
                        state_q          <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        DATA_MOUSE_OUT_EN <= 1'b1;
                        state_q           <= S_RTS;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RTS: begin
                    CLK_MOUSE_OUT_EN <= 1'b0;
                    cnt_q            <= '0;
                    state_q          <= S_SHIFT;
                end
                S_SHIFT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (tmo) begin
                        DATA_MOUSE_OUT_EN <= 1'b0;
                        ACK_ERR           <= 1'b1;
                        BUSY              <= 1'b0;
                        state_q           <= S_IDLE;
                    end else if (fall) begin
                        DATA_MOUSE_OUT_EN <= ~frame_q[0];
                        frame_q           <= {1'b1, frame_q[9:1]};
                        bits_q            <= bits_q + 4'd1;
                        if (bits_q == 4'd9) begin
                            state_q <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (fall) begin
                        if (data_s_q[1]) begin
                            ACK_ERR <= 1'b1;
                            BUSY    <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else if (tmo) begin
                        ACK_ERR <= 1'b1;
                        BUSY    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RELEASE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (clk_s_q[1] && data_s_q[1]) begin
                        BYTE_SENT <= 1'b1;
                        BUSY      <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (tmo) begin
                        ACK_ERR <= 1'b1;
                        BUSY    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    CLK_MOUSE_OUT_EN  <= 1'b0;
                    DATA_MOUSE_OUT_EN <= 1'b0;
                    BUSY              <= 1'b0;
                    state_q           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table of command bytes against a PS/2 device
// model, plus hand sequences for timeout, ignored resend and reset.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int TMO  = 3000;
    localparam int HALF = 15;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_BYTE = 1'b0;
    logic [7:0] BYTE_TO_SEND = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_pin;
    logic       data_pin;
    logic       CLK_MOUSE_OUT_EN;
    logic       DATA_MOUSE_OUT_EN;
    logic       BUSY;
    logic       BYTE_SENT;
    logic       ACK_ERR;

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_q[$];
    logic       out_q[$];

    typedef struct {
        logic [7:0] b;
        logic       ack;
        logic [9:0] frame;
        logic       sent;
    } vec_t;

    vec_t vecs[5];

    assign clk_pin  = CLK_MOUSE_OUT_EN  ? 1'b0 : dev_clk;
    assign data_pin = DATA_MOUSE_OUT_EN ? 1'b0 : dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .CLK_MOUSE_IN     (clk_pin),
        .DATA_MOUSE_IN    (data_pin),
        .CLK_MOUSE_OUT_EN (CLK_MOUSE_OUT_EN),
        .DATA_MOUSE_OUT_EN(DATA_MOUSE_OUT_EN),
        .SEND_BYTE        (SEND_BYTE),
        .BYTE_TO_SEND     (BYTE_TO_SEND),
        .BUSY             (BUSY),
        .BYTE_SENT        (BYTE_SENT),
        .ACK_ERR          (ACK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Scoreboard side: every completion pulse must match a queued outcome.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (BYTE_SENT && ACK_ERR) begin
                chk("pulse_exclusive", 32'd1, 32'd0);
            end else if (BYTE_SENT || ACK_ERR) begin
                if (out_q.size() == 0)
                    chk("unexpected_pulse", {31'd0, BYTE_SENT}, 32'd2);
                else
                    chk("outcome", {31'd0, BYTE_SENT},
                        {31'd0, out_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        int dat_at;
        @(posedge CLK);
        #1;
        SEND_BYTE    = 1'b1;
        BYTE_TO_SEND = b;
        @(posedge CLK);
        #1;
        SEND_BYTE = 1'b0;
        chk("busy_on_accept", {31'd0, BUSY}, 32'd1);
        n = 0;
        dat_at = 0;
        while (CLK_MOUSE_OUT_EN && n < INH * 4) begin
            n++;
            if (DATA_MOUSE_OUT_EN && dat_at == 0) dat_at = n;
            @(posedge CLK);
            #1;
        end
        chk("inhibit_len", n, INH);
        chk("rts_lead", dat_at, INH);
    endtask

    task automatic wait_rts(output logic ok);
        int w;
        w = 0;
        while (!(CLK_MOUSE_OUT_EN == 1'b0 && DATA_MOUSE_OUT_EN == 1'b1)
               && w < INH * 4) begin
            cyc(1);
            w++;
        end
        ok = (w < INH * 4);
    endtask

    task automatic dev_frame(input logic ack, output logic [9:0] cap,
                             output logic ok);
        cap = '0;
        wait_rts(ok);
        for (int i = 0; i < 10; i++) begin
            cyc(HALF);
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
            #1;
            cap[i] = data_pin;
        end
        cyc(HALF);
        if (ack) dev_data = 1'b0;
        cyc(5);
        dev_clk = 1'b0;
        cyc(HALF);
        dev_clk = 1'b1;
        cyc(5);
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("idle_reached", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        #1;
        chk("clk_released", {31'd0, CLK_MOUSE_OUT_EN}, 32'd0);
        chk("data_released", {31'd0, DATA_MOUSE_OUT_EN}, 32'd0);
        chk("outcome_drained", out_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0] cap;
        logic       ok;
        out_q.push_back(v.sent);
        exp_q.push_back(v.frame);
        fork
            send_byte(v.b);
            dev_frame(v.ack, cap, ok);
        join
        chk("rts_seen", {31'd0, ok}, 32'd1);
        if (exp_q.size() == 0)
            chk("frame_queue", 32'd0, 32'd1);
        else
            chk("frame", {22'd0, cap}, {22'd0, exp_q.pop_front()});
        wait_idle();
    endtask

    initial begin
        vecs[0] = '{b: 8'hF4, ack: 1'b1, frame: 10'h2F4, sent: 1'b1};
        vecs[1] = '{b: 8'h00, ack: 1'b1, frame: 10'h300, sent: 1'b1};
        vecs[2] = '{b: 8'hFF, ack: 1'b1, frame: 10'h3FF, sent: 1'b1};
        vecs[3] = '{b: 8'h55, ack: 1'b0, frame: 10'h355, sent: 1'b0};
        vecs[4] = '{b: 8'h01, ack: 1'b1, frame: 10'h201, sent: 1'b1};

        #1;
        chk("rst_clk_en", {31'd0, CLK_MOUSE_OUT_EN}, 32'd0);
        chk("rst_data_en", {31'd0, DATA_MOUSE_OUT_EN}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_sent", {31'd0, BYTE_SENT}, 32'd0);
        chk("rst_err", {31'd0, ACK_ERR}, 32'd0);
        cyc(3);
        RESET = 1'b0;
        cyc(3);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Device never clocks; a second request mid-frame is dropped.
        begin
            int k;
            out_q.push_back(1'b0);
            send_byte(8'h12);
            k = 0;
            while (!ACK_ERR && k < TMO + 200) begin
                @(posedge CLK);
                #1;
                k++;
                if (k == 100) begin
                    SEND_BYTE    = 1'b1;
                    BYTE_TO_SEND = 8'h34;
                end
                if (k == 101) SEND_BYTE = 1'b0;
            end
            chk("timeout_len", k, TMO);
            chk("timeout_busy", {31'd0, BUSY}, 32'd0);
            wait_idle();
            cyc(20);
            chk("no_queued_send", {31'd0, BUSY}, 32'd0);
        end

        // Asynchronous reset in the middle of the data bits.
        fork
            send_byte(8'hC3);
            begin
                logic ok;
                wait_rts(ok);
                chk("rst_rts_seen", {31'd0, ok}, 32'd1);
                for (int i = 0; i < 5; i++) begin
                    cyc(HALF);
                    dev_clk = 1'b0;
                    if (i < 4) begin
                        cyc(HALF);
                        dev_clk = 1'b1;
                    end
                end
                cyc(5);
                chk("mid_busy", {31'd0, BUSY}, 32'd1);
                chk("mid_data_en", {31'd0, DATA_MOUSE_OUT_EN}, 32'd1);
                #1;
                RESET = 1'b1;
                #1;
                chk("async_clk_en", {31'd0, CLK_MOUSE_OUT_EN}, 32'd0);
                chk("async_data_en", {31'd0, DATA_MOUSE_OUT_EN}, 32'd0);
                chk("async_busy", {31'd0, BUSY}, 32'd0);
            end
        join
        dev_clk = 1'b1;
        cyc(3);
        RESET = 1'b0;
        cyc(3);
        chk("post_rst_drained", out_q.size(), 0);
        run_vec(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
